shl_64b: RTL and testbench



---
 rtl/shl_64b_pkg.sv | 18 +
 rtl/shl_64b_stage.sv | 27 ++
 rtl/shl_64b.sv | 105 ++++++++++
 tb/tb_shl_64b.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shl_64b_pkg.sv
// ============================================================================
// Module : shl_pkg
// Brief  : Shared widths and types for the 64-bit left barrel shifter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package shl_pkg;

    localparam int DATA_W  = 64;
    localparam int SHIFT_W = 6;

    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [SHIFT_W-1:0] shift_t;

endpackage : shl_pkg

`default_nettype wire

// File: rtl/shl_64b_stage.sv
// ============================================================================
// Module : shl_stage
// Brief  : One level of the log shifter: optional left shift by STEP with
//          the vacated low bits filled from carry_i.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shl_stage
    import shl_pkg::*;
#(
    parameter int STEP = 1
) (
    input  data_t in_data_i,
    input  logic  carry_i,
    input  logic  en_i,
    output data_t out_data_o
);

    data_t w_shifted;

    assign w_shifted  = {in_data_i[DATA_W-1-STEP:0], {STEP{carry_i}}};
    assign out_data_o = en_i ? w_shifted : in_data_i;

endmodule : shl_stage

`default_nettype wire

// File: rtl/shl_64b.sv
// ============================================================================
// Module : shl_64b
// Brief  : 64-bit logical left barrel shifter with programmable fill bit and
//          optional output register (REG_OUT). Macro SHL_64B_CARRY_OUT_EN adds
//          out_carry_o, the last bit shifted out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shl_64b
    import shl_pkg::*;
#(
    parameter int REG_OUT = 1
) (
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  logic   carry_i,
    input  shift_t shift_i,
    input  data_t  in_data_i,
    input  logic   in_valid_i,
    output data_t  out_data_o,
`ifdef SHL_64B_CARRY_OUT_EN
    output logic   out_carry_o,
`endif
    output logic   out_valid_o
);

    // Stage 0 shifts by 32, the last stage by 1, so every amount sees 6 muxes.
    data_t w_stage [0:SHIFT_W];

    assign w_stage[0] = in_data_i;

    for (genvar i = 0; i < SHIFT_W; i++) begin : g_stage
        shl_stage #(
            .STEP (1 << (SHIFT_W - 1 - i))
        ) u_stage (
            .in_data_i  (w_stage[i]),
            .carry_i    (carry_i),
            .en_i       (shift_i[SHIFT_W-1-i]),
            .out_data_o (w_stage[i+1])
        );
    end

    data_t w_result;
    assign w_result = w_stage[SHIFT_W];

`ifdef SHL_64B_CARRY_OUT_EN
    // Modulo-64 negate yields 64-shift for every non-zero amount.
    shift_t w_out_idx;
    logic   w_carry_out;

    assign w_out_idx   = shift_t'(0) - shift_i;
    assign w_carry_out = (shift_i == '0) ? 1'b0 : in_data_i[w_out_idx];
`endif

    if (REG_OUT != 0) begin : g_reg
        data_t out_data_d, out_data_q;
        logic  out_valid_q;

        always_comb begin
            out_data_d = out_data_q;
            if (in_valid_i) begin
                out_data_d = w_result;
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_data_q  <= out_data_d;
                out_valid_q <= in_valid_i;
            end
        end

        assign out_data_o  = out_data_q;
        assign out_valid_o = out_valid_q;

`ifdef SHL_64B_CARRY_OUT_EN
        logic out_carry_d, out_carry_q;

        assign out_carry_d = in_valid_i ? w_carry_out : out_carry_q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                out_carry_q <= 1'b0;
            end else begin
                out_carry_q <= out_carry_d;
            end
        end

        assign out_carry_o = out_carry_q;
`endif
    end else begin : g_comb
        assign out_data_o  = w_result;
        assign out_valid_o = in_valid_i;
`ifdef SHL_64B_CARRY_OUT_EN
        assign out_carry_o = w_carry_out;
`endif
    end

endmodule : shl_64b

`default_nettype wire

// File: tb/tb_shl_64b.sv
// ============================================================================
// Module : tb_shl_64b
// Brief  : Scoreboard bench for shl_64b (REG_OUT=1), with directed vectors,
//          a sweep, random traffic and an asynchronous reset mid-stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_shl_64b;

    logic        clk;
    logic        rst_n;
    logic        carry;
    logic [5:0]  shift;
    logic [63:0] in_data;
    logic        in_valid;
    logic [63:0] out_data;
    logic        out_valid;
`ifdef SHL_64B_CARRY_OUT_EN
    logic        out_carry;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        co;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] m_data;
    logic        m_carry;

    shl_64b #(
        .REG_OUT (1)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .carry_i     (carry),
        .shift_i     (shift),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .out_data_o  (out_data),
`ifdef SHL_64B_CARRY_OUT_EN
        .out_carry_o (out_carry),
`endif
        .out_valid_o (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_shl(logic [63:0] d, int sh, logic c);
        logic [63:0] fill;
        fill = c ? ((64'd1 << sh) - 64'd1) : 64'd0;
        return (d << sh) | fill;
    endfunction

    function automatic logic ref_cout(logic [63:0] d, int sh);
        return (sh == 0) ? 1'b0 : d[64-sh];
    endfunction

    // Drive one cycle of inputs; after the sampling edge record what the DUT
    // must show, using the caller's explicit value when use_exp is set.
    task automatic cycle(input logic v, input logic [63:0] d, input int sh,
                         input logic c, input bit use_exp, input logic [63:0] exp_d);
        exp_t e;
        in_valid = v;
        in_data  = d;
        shift    = 6'(sh);
        carry    = c;
        @(posedge clk);
        if (v) begin
            m_data  = use_exp ? exp_d : ref_shl(d, sh, c);
            m_carry = ref_cout(d, sh);
        end
        e.v  = v;
        e.d  = m_data;
        e.co = m_carry;
        sb_q.push_back(e);
        #1;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (out_data !== 64'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: data=%h valid=%b required data=0 valid=0",
                     name, out_data, out_valid);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (out_valid !== e.v || out_data !== e.d) begin
                errors++;
                $display("FAIL out: data=%h valid=%b required data=%h valid=%b",
                         out_data, out_valid, e.d, e.v);
            end
`ifdef SHL_64B_CARRY_OUT_EN
            checks++;
            if (out_carry !== e.co) begin
                errors++;
                $display("FAIL carry_out: got %b required %b", out_carry, e.co);
            end
`endif
        end
    end

    logic [63:0] sweep_pat [5];

    initial begin
        sweep_pat[0] = 64'h0123456789abcdef;
        sweep_pat[1] = 64'hfedcba9876543210;
        sweep_pat[2] = 64'hffffffffffffffff;
        sweep_pat[3] = 64'h8000000000000000;
        sweep_pat[4] = 64'h4000000000000000;

        m_data   = '0;
        m_carry  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        shift    = '0;
        carry    = 1'b0;
        rst_n    = 1'b0;
        #12;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors with hand-computed results.
        cycle(1, 64'h0123456789abcdef, 0,  0, 1, 64'h0123456789abcdef);
        cycle(1, 64'h0123456789abcdef, 4,  0, 1, 64'h123456789abcdef0);
        cycle(1, 64'h0123456789abcdef, 4,  1, 1, 64'h123456789abcdeff);
        cycle(1, 64'h8000000000000000, 1,  1, 1, 64'h0000000000000001);
        cycle(1, 64'hffffffffffffffff, 63, 0, 1, 64'h8000000000000000);
        cycle(1, 64'h4000000000000000, 1,  0, 1, 64'h8000000000000000);
        cycle(1, 64'hfedcba9876543210, 63, 1, 1, 64'h7fffffffffffffff);
        cycle(1, 64'h0123456789abcdef, 0,  1, 1, 64'h0123456789abcdef);
        cycle(0, 64'h5555aaaa5555aaaa, 7,  1, 0, 64'd0);
        cycle(0, 64'h1111111111111111, 9,  0, 0, 64'd0);

        // Full sweep; reset is pulsed between edges part-way through.
        for (int p = 0; p < 5; p++) begin
            for (int sh = 0; sh < 64; sh++) begin
                for (int c = 0; c < 2; c++) begin
                    cycle(1, sweep_pat[p], sh, c[0], 0, 64'd0);
                    if (p == 2 && sh == 20 && c == 1) begin
                        #2;
                        rst_n = 1'b0;
                        #1;
                        check_zero("async_reset");
                        sb_q.delete();
                        m_data  = '0;
                        m_carry = 1'b0;
                        in_valid = 1'b1;
                        in_data  = 64'hdeadbeefdeadbeef;
                        shift    = 6'd3;
                        @(posedge clk);
                        #1;
                        check_zero("reset_held");
                        rst_n = 1'b1;
                        cycle(0, 64'hcafef00dcafef00d, 5, 1, 0, 64'd0);
                        cycle(0, 64'hcafef00dcafef00d, 6, 0, 0, 64'd0);
                    end
                end
            end
        end

        // Random traffic with sparse valid to exercise hold behaviour.
        for (int n = 0; n < 400; n++) begin
            logic [63:0] d;
            d = {$urandom(), $urandom()};
            cycle(($urandom_range(0, 3) != 0), d, int'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)), 0, 64'd0);
        end
        cycle(0, 64'd0, 0, 0, 0, 64'd0);
        cycle(0, 64'd0, 0, 0, 0, 64'd0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shl_64b

`default_nettype wire
